// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the multicycle controller.
//
// Holds the FSM state enumeration (plus plain 3-bit constants used by the
// FSM register), the RV32 major-opcode constants, the decoded opcode-class
// enumeration and the special encodings driven on pc_sel, wb_sel and
// alu_ctrl. Imported by ctrl_decode and multicycle_controller.

package ctrl_pkg;

  // FSM states; the numeric values are visible on the debug 'state' port.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // The FSM register is a plain vector compared against these constants.
  localparam logic [2:0] ST_FETCH  = S_FETCH;
  localparam logic [2:0] ST_DECODE = S_DECODE;
  localparam logic [2:0] ST_EXEC   = S_EXEC;
  localparam logic [2:0] ST_MEM    = S_MEM;
  localparam logic [2:0] ST_WB     = S_WB;
  localparam logic [2:0] ST_TRAP   = S_TRAP;

  // Major opcodes, ir[6:2].
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;

  // Opcode class captured in DECODE and used by the rest of the sequence.
  typedef enum logic [3:0] {
    CL_OP,
    CL_OP_IMM,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC,
    CL_ILLEGAL
  } op_class_e;

  // PC source select.
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // Writeback source select.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // ALU operations that are not derived from funct3/funct7.
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_LUI  = 5'b11000;
  localparam logic [4:0] ALU_JALR = 5'b11001;

  // Access size used for instruction fetch (and idle value of mem_size).
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // True for the classes that need a data-memory access.
  function automatic logic is_mem_class(input op_class_e c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- combinational instruction decoder.
//
// Maps the instruction register onto an opcode class, the ALU operation,
// the ALU operand-B select and a legality flag. Anything whose low two bits
// are not 11, or whose major opcode is not in the supported set, is illegal.
//
// Ports:
//   ir        in  32  instruction register contents
//   op_class  out     decoded opcode class (CL_ILLEGAL when not legal)
//   alu_ctrl  out  5  ALU operation
//   alu_imm   out  1  ALU operand-B is the immediate
//   legal     out  1  instruction is supported

module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output op_class_e   op_class,
  output logic [4:0]  alu_ctrl,
  output logic        alu_imm,
  output logic        legal
);

  logic [2:0] funct3;
  logic       unused_ir;

  assign funct3 = ir[14:12];

  // Only opcode, funct3 and funct7[5] steer the control path.
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  always_comb begin
    op_class = CL_ILLEGAL;
    alu_ctrl = ALU_ADD;
    alu_imm  = 1'b0;
    if (ir[1:0] == 2'b11) begin
      case (ir[6:2])
        OPC_OP: begin
          op_class = CL_OP;
          alu_ctrl = {1'b0, ir[30], funct3};
        end
        OPC_OP_IMM: begin
          // ir[30] is only an opcode modifier for shift-right immediates;
          // for every other funct3 it is part of the immediate.
          op_class = CL_OP_IMM;
          alu_ctrl = {1'b0, (funct3 == 3'b101) & ir[30], funct3};
          alu_imm  = 1'b1;
        end
        OPC_LOAD: begin
          op_class = CL_LOAD;
          alu_imm  = 1'b1;
        end
        OPC_STORE: begin
          op_class = CL_STORE;
          alu_imm  = 1'b1;
        end
        OPC_BRANCH: begin
          op_class = CL_BRANCH;
          alu_ctrl = {2'b10, funct3};
        end
        OPC_JAL: begin
          op_class = CL_JAL;
        end
        OPC_JALR: begin
          op_class = CL_JALR;
          alu_ctrl = ALU_JALR;
          alu_imm  = 1'b1;
        end
        OPC_LUI: begin
          op_class = CL_LUI;
          alu_ctrl = ALU_LUI;
          alu_imm  = 1'b1;
        end
        OPC_AUIPC: begin
          op_class = CL_AUIPC;
          alu_imm  = 1'b1;
        end
        default: ;
      endcase
    end
    legal = (op_class != CL_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller -- FETCH/DECODE/EXEC/MEM/WB control FSM for a
// multicycle RV32 datapath.
//
// Optional feature: define MULTICYCLE_CONTROLLER_TRAP_EN to add the memory
// wait timeout and the TRAP state (illegal instructions and timeouts then
// trap and set the sticky fault flag). Without it, illegal instructions act
// as NOPs, memory waits are unbounded and fault is tied low.
//
// Parameters:
//   MEM_TIMEOUT  wait cycles tolerated on mem_ready before a timeout (>= 1)
//   SIZE_W       width of mem_size (10 word, 01 half, 00 byte)
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ir                 instruction register, valid from DECODE onward
//   br_taken           branch condition, used in EXEC
//   mem_ready          acknowledge for the outstanding mem_req
//   mem_req/we/size    memory request, write enable, access size
//   ld_ir, ld_pc       IR and PC load strobes
//   pc_sel             PC source (00 PC+4, 01 PC+imm, 10 ALU)
//   alu_ctrl, alu_imm  ALU operation and operand-B select
//   reg_we, wb_sel     register write strobe and writeback source
//   state, fault       debug state and sticky trap flag

module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int SIZE_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ir,
  input  logic              br_taken,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [SIZE_W-1:0] mem_size,
  output logic              ld_ir,
  output logic              ld_pc,
  output logic [1:0]        pc_sel,
  output logic [4:0]        alu_ctrl,
  output logic              alu_imm,
  output logic              reg_we,
  output logic [1:0]        wb_sel,
  output logic [2:0]        state,
  output logic              fault
);

`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
  localparam bit TRAP_ENABLED = 1'b1;
`else
  localparam bit TRAP_ENABLED = 1'b0;
`endif

  logic [2:0] state_q;
  logic [2:0] state_d;
  op_class_e  class_q;
  logic       legal_q;

  op_class_e  dec_class;
  logic [4:0] dec_alu_ctrl;
  logic       dec_alu_imm;
  logic       dec_legal;

  logic       in_access;
  logic       mem_wait;
  logic       timeout;

  ctrl_decode u_decode (
    .ir       (ir),
    .op_class (dec_class),
    .alu_ctrl (dec_alu_ctrl),
    .alu_imm  (dec_alu_imm),
    .legal    (dec_legal)
  );

  // FETCH and MEM are the only states that hold a memory request open.
  assign in_access = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign mem_wait  = in_access && !mem_ready;

`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
  localparam int              CNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;
  logic             entering_access;
  logic             fault_q;

  assign entering_access = (state_d != state_q) &&
                           ((state_d == ST_FETCH) || (state_d == ST_MEM));

  // Wait counter: restarts with every new access and saturates at the
  // limit. A mem_ready in the cycle the limit is reached still completes
  // the access, so the timeout only fires when that cycle is also a wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (entering_access) begin
      wait_cnt <= '0;
    end else if (mem_wait && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = mem_wait && (wait_cnt == CNT_MAX);

  // Sticky fault: once TRAP is entered only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (state_d == ST_TRAP) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  logic unused_timeout;

  // Waits are unbounded in this build, so the limit has no effect.
  assign unused_timeout = ^MEM_TIMEOUT;
  assign timeout        = 1'b0;
  assign fault          = 1'b0;
`endif

  // State register plus the opcode class latched during DECODE; ir stays
  // valid afterwards, but the class is held so the sequencing does not
  // depend on the live instruction word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      class_q <= CL_ILLEGAL;
      legal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        class_q <= dec_class;
        legal_q <= dec_legal;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        state_d = (TRAP_ENABLED && !dec_legal) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        // Illegal instructions only reach EXEC when they are treated as
        // NOPs; they retire here just like a branch.
        if (!legal_q || (class_q == CL_BRANCH)) begin
          state_d = ST_FETCH;
        end else if (is_mem_class(class_q)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = (class_q == CL_LOAD) ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output decode. Everything is forced to its idle value while rst_n is
  // low so that an access in flight is dropped the moment reset asserts,
  // not at the next clock edge.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_size = SIZE_W'(SIZE_WORD);
    ld_ir    = 1'b0;
    ld_pc    = 1'b0;
    pc_sel   = PC_PLUS4;
    alu_ctrl = ALU_ADD;
    alu_imm  = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ld_ir   = mem_ready;
        end
        ST_EXEC: begin
          alu_ctrl = dec_alu_ctrl;
          alu_imm  = dec_alu_imm;
          if (!legal_q) begin
            ld_pc = 1'b1;
          end else if (class_q == CL_BRANCH) begin
            ld_pc  = 1'b1;
            pc_sel = br_taken ? PC_IMM : PC_PLUS4;
          end
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          mem_we   = (class_q == CL_STORE);
          mem_size = SIZE_W'(ir[13:12]);
          // A store has nothing to write back, so it retires on the ack.
          ld_pc    = mem_ready && (class_q == CL_STORE);
        end
        ST_WB: begin
          reg_we = 1'b1;
          ld_pc  = 1'b1;
          case (class_q)
            CL_LOAD: wb_sel = WB_MEM;
            CL_JAL: begin
              wb_sel = WB_PC4;
              pc_sel = PC_IMM;
            end
            CL_JALR: begin
              wb_sel = WB_PC4;
              pc_sel = PC_ALU;
            end
            CL_LUI:  wb_sel = WB_IMM;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of wait cycles for mem_ready before a fault (minimum 1).
REQ-002 SHALL have parameter SIZE_W, default 2, meaning the width of mem_size (10=word, 01=half, 00=byte).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 ir  in  32  instruction register contents, valid from DECODE onward.
REQ-006 br_taken  in  1  branch condition from the ALU, sampled in EXEC.
REQ-007 mem_ready  in  1  memory acknowledge for the current mem_req.
REQ-008 mem_req  out  1  memory access request; mem_we  out  1  write enable; mem_size  out  SIZE_W  access size.
REQ-009 ld_ir  out  1  IR load strobe; ld_pc  out  1  PC load strobe; pc_sel  out  2  PC source (00 PC+4, 01 PC+imm, 10 ALU result).
REQ-010 alu_ctrl  out  5  ALU operation; alu_imm  out  1  ALU operand-B select (1 = immediate).
REQ-011 reg_we  out  1  register write; wb_sel  out  2  writeback source (00 ALU, 01 memory, 10 PC+4, 11 immediate).
REQ-012 state  out  3  current FSM state, for debug; fault  out  1  sticky trap flag.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5.
REQ-014 FETCH behaviour:
- mem_req=1, mem_we=0, mem_size=10.
- When mem_ready=1: ld_ir pulses for exactly one cycle and the FSM moves to DECODE.
REQ-015 DECODE SHALL take exactly one cycle; it SHALL register the opcode class from ir[6:2] and move to EXEC; ir[1:0]!=11 or an unlisted opcode is illegal.
REQ-016 alu_ctrl encoding:
- OP: {0,ir[30],ir[14:12]}.
- OP-IMM: {0, ir[30] only when funct3=101, ir[14:12]}.
- BRANCH: {1,0,ir[14:12]}.
- LOAD/STORE/AUIPC/JAL: 00000.
- LUI: 11000.
- JALR: 11001.
REQ-017 EXEC for BRANCH: ld_pc=1 with pc_sel=01 if br_taken, else 00; next state FETCH.
REQ-018 EXEC routing: LOAD/STORE go to MEM; all other legal classes go to WB.
REQ-019 MEM behaviour:
- mem_req=1; mem_we=1 only for STORE; mem_size=ir[13:12].
- On mem_ready, a LOAD moves to WB.
- On mem_ready, a STORE pulses ld_pc with pc_sel=00 and moves to FETCH.
REQ-020 WB SHALL pulse reg_we and ld_pc for one cycle, then move to FETCH:
- OP/OP-IMM: wb_sel=00.
- LOAD: wb_sel=01.
- JAL: wb_sel=10, pc_sel=01.
- JALR: wb_sel=10, pc_sel=10.
- LUI: wb_sel=11.
- AUIPC: wb_sel=00.
- In every case not listed above, pc_sel=00.
REQ-021 Timeout counter:
- Width $clog2(MEM_TIMEOUT+1).
- Clears on entry to FETCH or MEM and counts each cycle in which mem_req=1 and mem_ready=0.
- Reaching MEM_TIMEOUT is a timeout event (see REQ-026).
REQ-022 mem_ready asserted in the same cycle the counter reaches MEM_TIMEOUT SHALL win; the access completes normally.
REQ-023 All strobes (ld_ir, ld_pc, reg_we) SHALL be single-cycle; mem_req SHALL stay high continuously until acknowledged.

Reset
REQ-024 While rst_n=0:
- state=FETCH, counter=0, fault=0.
- All strobes, mem_req, mem_we, alu_imm = 0.
- alu_ctrl, pc_sel, wb_sel = 0; mem_size=10.
REQ-025 Reset asserted mid-access SHALL abandon the access immediately; after release, the first cycle is FETCH with mem_req=1.

Configuration
REQ-026 With macro MULTICYCLE_CONTROLLER_TRAP_EN defined:
- An illegal instruction in DECODE, or a timeout, SHALL go to TRAP.
- TRAP sets fault=1, drives all strobes and mem_req to 0, and holds until reset.
REQ-027 Without MULTICYCLE_CONTROLLER_TRAP_EN:
- An illegal instruction SHALL behave as a NOP (EXEC pulses ld_pc with pc_sel=00, then FETCH).
- The timeout counter SHALL be absent; waits are unbounded.
- fault SHALL be tied to 0 and TRAP is unreachable.

Structure
REQ-028 A shared package ctrl_pkg SHALL hold:
- the state enum;
- opcode constants (OP=01100, OP_IMM=00100, LOAD=00000, STORE=01000, BRANCH=11000, JAL=11011, JALR=11001, LUI=01101, AUIPC=00101);
- the pc_sel, wb_sel and alu_ctrl special-encoding constants.
REQ-029 A combinational sub-module ctrl_decode SHALL map ir to opcode class, alu_ctrl, alu_imm and legality; the FSM and timeout counter stay in multicycle_controller.

Verification
REQ-030 Directed scenarios:
- ADD 0x002081B3 with mem_ready=1 in the first FETCH cycle -> ld_ir at cycle 0; alu_ctrl=00000 in EXEC; reg_we=1, wb_sel=00, pc_sel=00 in WB (cycle 3).
- BEQ 0x00208463 with br_taken=1 -> alu_ctrl=10000, ld_pc=1, pc_sel=01 in EXEC, then FETCH; with br_taken=0 -> pc_sel=00.
- LW 0x0000A183 with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, mem_size=10, then WB with wb_sel=01.
- SB 0x00308023 -> mem_we=1, mem_size=00; no reg_we; ld_pc in the acknowledge cycle.
- TRAP_EN: ir=0x00000000 -> TRAP, fault=1, no further mem_req; mem_ready never asserted in FETCH -> TRAP after 15 wait cycles; mem_ready at wait 15 -> normal DECODE.
- rst_n pulsed low during MEM -> all outputs at reset values asynchronously; FETCH on release.
